// File: rtl/unlock_ctrl_if.sv
// Handshake bundle between the digit-entry/comparator side and the unlock sequencer.
interface unlock_ctrl_if;
  logic       check;
  logic       match;
  logic       lock_req;
  logic       judge_en;
  logic       unlock;
  logic       alarm;
  logic       clr_entry;
  logic       busy;
  logic [3:0] fail_cnt;

  modport master (
    output check, match, lock_req,
    input  judge_en, unlock, alarm, clr_entry, busy, fail_cnt
  );

  modport slave (
    input  check, match, lock_req,
    output judge_en, unlock, alarm, clr_entry, busy, fail_cnt
  );
endinterface

// File: rtl/unlock_ctrl.sv
// Unlock sequencer: triggers the password comparator, acts on its verdict,
// holds the lock open for a fixed time, and enforces an alarm lockout after
// too many consecutive wrong entries.
module unlock_ctrl #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYC    = 250_000_000,
  parameter int unsigned LOCKOUT_CYC = 500_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  unlock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JUDGE   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Timers count down from N-1 so that the output stays asserted for exactly N cycles.
  localparam logic [31:0] OPEN_LOAD = 32'(OPEN_CYC - 1);
  localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYC - 1);
  // Failure count at which one more wrong entry triggers lockout.
  localparam logic [3:0]  FAIL_LAST = 4'(MAX_FAIL - 1);

  state_t      state_r;
  logic        judge_ph_r;   // 0 = first JUDGE cycle, 1 = second (verdict edge next)
  logic [31:0] timer_r;
  logic [3:0]  fail_cnt_r;
  logic        judge_en_r;
  logic        unlock_r;
  logic        alarm_r;
  logic        clr_entry_r;
  logic        busy_r;
  logic        timer_zero_s;

  assign timer_zero_s = (timer_r == 32'd0);

  assign bus.judge_en  = judge_en_r;
  assign bus.unlock    = unlock_r;
  assign bus.alarm     = alarm_r;
  assign bus.clr_entry = clr_entry_r;
  assign bus.busy      = busy_r;
  assign bus.fail_cnt  = fail_cnt_r;

  // Sequencer state, timer, failure counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      judge_ph_r  <= 1'b0;
      timer_r     <= 32'd0;
      fail_cnt_r  <= 4'd0;
      judge_en_r  <= 1'b0;
      unlock_r    <= 1'b0;
      alarm_r     <= 1'b0;
      clr_entry_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      clr_entry_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.check) begin
            state_r    <= JUDGE;
            judge_ph_r <= 1'b0;
            judge_en_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        JUDGE: begin
          if (!judge_ph_r) begin
            judge_ph_r <= 1'b1;
          end else begin
            // Verdict edge: comparator result is sampled here.
            judge_ph_r  <= 1'b0;
            judge_en_r  <= 1'b0;
            clr_entry_r <= 1'b1;
            if (bus.match) begin
              fail_cnt_r <= 4'd0;
              unlock_r   <= 1'b1;
              timer_r    <= OPEN_LOAD;
              state_r    <= OPEN;
            end else if (fail_cnt_r == FAIL_LAST) begin
              fail_cnt_r <= 4'd0;
              alarm_r    <= 1'b1;
              timer_r    <= LOCK_LOAD;
              state_r    <= LOCKOUT;
            end else begin
              fail_cnt_r <= fail_cnt_r + 4'd1;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end
          end
        end
        OPEN: begin
          // Relock request and expiry coinciding still give one return to IDLE.
          if (bus.lock_req || timer_zero_s) begin
            unlock_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        LOCKOUT: begin
          if (timer_zero_s) begin
            alarm_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          judge_ph_r <= 1'b0;
          timer_r    <= 32'd0;
          judge_en_r <= 1'b0;
          unlock_r   <= 1'b0;
          alarm_r    <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_ctrl.sv
// Self-checking bench for unlock_ctrl: directed scenarios plus random traffic,
// all outputs compared every cycle against a timestamp-based behavioural model.
module tb_unlock_ctrl;
  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYC    = 8;
  localparam int LOCKOUT_CYC = 10;

  logic clk = 1'b0;
  logic rst_n;
  unlock_ctrl_if bus ();

  unlock_ctrl #(
    .MAX_FAIL   (MAX_FAIL),
    .OPEN_CYC   (OPEN_CYC),
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the verdict edge is two edges after the accepted check,
  // and unlock/alarm are "high while edge index < end edge".
  int   n           = 0;
  int   judge_at    = -1;
  int   open_until  = 0;
  int   alarm_until = 0;
  int   fails       = 0;
  logic exp_judge   = 1'b0;
  logic exp_unlock  = 1'b0;
  logic exp_alarm   = 1'b0;
  logic exp_clr     = 1'b0;
  logic exp_busy    = 1'b0;
  int   exp_fail    = 0;

  // Reference model update at each active edge.
  always @(posedge clk) begin : model
    int ja, ou, au, fc;
    bit clr;
    ja = judge_at; ou = open_until; au = alarm_until; fc = fails; clr = 1'b0;
    if (!rst_n) begin
      ja = -1; ou = 0; au = 0; fc = 0;
    end else if (ja >= 0) begin
      if (n == ja + 2) begin
        clr = 1'b1;
        ja  = -1;
        if (bus.match) begin
          fc = 0; ou = n + OPEN_CYC;
        end else if (fc + 1 < MAX_FAIL) begin
          fc = fc + 1;
        end else begin
          fc = 0; au = n + LOCKOUT_CYC;
        end
      end
    end else if (exp_unlock) begin
      if (bus.lock_req && n < ou) ou = n;
    end else if (exp_alarm) begin
      ou = ou;
    end else if (bus.check) begin
      ja = n;
    end
    judge_at    <= ja;
    open_until  <= ou;
    alarm_until <= au;
    fails       <= fc;
    exp_judge   <= (ja >= 0);
    exp_unlock  <= (n < ou);
    exp_alarm   <= (n < au);
    exp_clr     <= clr;
    exp_fail    <= fc;
    exp_busy    <= (ja >= 0) || (n < ou) || (n < au);
    n           <= n + 1;
  end

  int cnt_unlock = 0;
  int cnt_alarm  = 0;
  int cnt_judge  = 0;
  int cnt_clr    = 0;

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("judge_en",  bus.judge_en,  exp_judge);
    chk("unlock",    bus.unlock,    exp_unlock);
    chk("alarm",     bus.alarm,     exp_alarm);
    chk("clr_entry", bus.clr_entry, exp_clr);
    chk("busy",      bus.busy,      exp_busy);
    chk("fail_cnt",  bus.fail_cnt,  exp_fail);
    cnt_unlock <= cnt_unlock + int'(bus.unlock);
    cnt_alarm  <= cnt_alarm  + int'(bus.alarm);
    cnt_judge  <= cnt_judge  + int'(bus.judge_en);
    cnt_clr    <= cnt_clr    + int'(bus.clr_entry);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_check(input logic m);
    bus.check = 1'b1;
    bus.match = m;
    tick(1);
    bus.check = 1'b0;
  endtask

  // Bounded wait for unlock (sel=0) or alarm (sel=1) to rise.
  task automatic wait_sig(input int sel, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((sel == 0 ? bus.unlock : bus.alarm) === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  int u0, a0, j0, c0;

  initial begin
    bus.check = 1'b1; bus.match = 1'b0; bus.lock_req = 1'b0; rst_n = 1'b0;

    // 1. reset with check held high
    tick(2);
    chk("rst_unlock", bus.unlock, 1'b0);
    chk("rst_alarm",  bus.alarm,  1'b0);
    chk("rst_judge",  bus.judge_en, 1'b0);
    chk("rst_busy",   bus.busy,   1'b0);
    chk("rst_fail",   bus.fail_cnt, 4'd0);
    rst_n = 1'b1; bus.check = 1'b0;
    tick(2);

    // 2. correct entry
    u0 = cnt_unlock; j0 = cnt_judge; c0 = cnt_clr;
    pulse_check(1'b1);
    tick(14);
    chk("t2_unlock_len", cnt_unlock - u0, 32'd8);
    chk("t2_judge_len",  cnt_judge - j0,  32'd2);
    chk("t2_clr_pulses", cnt_clr - c0,    32'd1);
    chk("t2_fail",       bus.fail_cnt,    4'd0);

    // 3. two wrong, then correct
    pulse_check(1'b0); tick(4);
    chk("t3_fail1", bus.fail_cnt, 4'd1);
    pulse_check(1'b0); tick(4);
    chk("t3_fail2", bus.fail_cnt, 4'd2);
    pulse_check(1'b1); tick(3);
    chk("t3_fail0", bus.fail_cnt, 4'd0);
    chk("t3_open",  bus.unlock,   1'b1);
    tick(10);

    // 4. three wrong -> lockout, checks ignored meanwhile
    pulse_check(1'b0); tick(4);
    pulse_check(1'b0); tick(4);
    a0 = cnt_alarm;
    pulse_check(1'b0);
    wait_sig(1, "t4_alarm_rise");
    j0 = cnt_judge;
    pulse_check(1'b1); tick(2);
    pulse_check(1'b1);
    for (int k = 0; k < 20 && bus.alarm === 1'b1; k++) tick(1);
    tick(2);
    chk("t4_alarm_len", cnt_alarm - a0, 32'd10);
    chk("t4_no_judge",  cnt_judge - j0, 32'd0);
    chk("t4_fail",      bus.fail_cnt,   4'd0);
    chk("t4_busy",      bus.busy,       1'b0);

    // 5a. relock on open cycle 3
    u0 = cnt_unlock;
    pulse_check(1'b1);
    wait_sig(0, "t5a_unlock_rise");
    tick(2);
    bus.lock_req = 1'b1; tick(1); bus.lock_req = 1'b0;
    chk("t5a_relock", bus.unlock, 1'b0);
    tick(3);
    chk("t5a_unlock_len", cnt_unlock - u0, 32'd3);

    // 5b. relock on the expiry cycle
    u0 = cnt_unlock;
    pulse_check(1'b1);
    wait_sig(0, "t5b_unlock_rise");
    tick(7);
    bus.lock_req = 1'b1; tick(1); bus.lock_req = 1'b0;
    chk("t5b_unlock", bus.unlock, 1'b0);
    chk("t5b_busy",   bus.busy,   1'b0);
    tick(3);
    chk("t5b_unlock_len", cnt_unlock - u0, 32'd8);
    chk("t5b_busy_after", bus.busy, 1'b0);

    // 6. reset during lockout, then a new check is accepted
    for (int r = 0; r < 3; r++) begin
      pulse_check(1'b0);
      if (r < 2) tick(4);
    end
    wait_sig(1, "t6_alarm_rise");
    tick(4);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("t6_alarm", bus.alarm, 1'b0);
    chk("t6_busy",  bus.busy,  1'b0);
    pulse_check(1'b1);
    chk("t6_judge", bus.judge_en, 1'b1);
    tick(14);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.check    = ($urandom % 4) == 0;
      bus.match    = ($urandom % 2) == 0;
      bus.lock_req = ($urandom % 8) == 0;
      rst_n        = ($urandom % 300) != 0;
      tick(1);
    end
    bus.check = 1'b0; rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
